// File: rtl/comp_minmax_scan_pkg.sv
// Shared definitions for the min/max scan sequencer: state encoding and default widths.
package comp_minmax_scan_pkg;

  localparam int DATAWIDTH_DEF = 64;
  localparam int CNTWIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/comp_minmax_scan_comp.sv
// Library magnitude comparator (COMP): unsigned, purely combinational.
module comp_minmax_scan_comp #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 gt,
  output logic                 lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/comp_minmax_scan.sv
// Streams Count operands through one shared comparator, tracking min/max and their indices.
module comp_minmax_scan
  import comp_minmax_scan_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int CNTWIDTH  = CNTWIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [CNTWIDTH-1:0]  Count,
  input  logic [DATAWIDTH-1:0] InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] Min,
  output logic [DATAWIDTH-1:0] Max,
  output logic [CNTWIDTH-1:0]  MinIdx,
  output logic [CNTWIDTH-1:0]  MaxIdx
);

  state_e                state_q, state_d;
  logic [CNTWIDTH-1:0]   rem_q, rem_d;
  logic [CNTWIDTH-1:0]   idx_q, idx_d;
  logic [DATAWIDTH-1:0]  cur_q, cur_d;
  logic [DATAWIDTH-1:0]  min_q, min_d;
  logic [DATAWIDTH-1:0]  max_q, max_d;
  logic [CNTWIDTH-1:0]   minidx_q, minidx_d;
  logic [CNTWIDTH-1:0]   maxidx_q, maxidx_d;

  logic [DATAWIDTH-1:0]  cmp_b;
  logic                  cmp_gt, cmp_lt;

  // One comparator serves both passes; b follows the state.
  assign cmp_b = (state_q == S_CMP_MAX) ? max_q : min_q;

  comp_minmax_scan_comp #(.DATAWIDTH(DATAWIDTH)) u_comp (
    .a  (cur_q),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    min_d    = min_q;
    max_d    = max_q;
    minidx_d = minidx_q;
    maxidx_d = maxidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Count != '0) begin
            rem_d   = Count;
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            min_d    = '0;
            max_d    = '0;
            minidx_d = '0;
            maxidx_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (InValid) begin
          cur_d = InData;
          if (idx_q == '0) begin
            min_d    = InData;
            max_d    = InData;
            minidx_d = '0;
            maxidx_d = '0;
            idx_d    = idx_q + CNTWIDTH'(1);
            rem_d    = rem_q - CNTWIDTH'(1);
            state_d  = (rem_q == CNTWIDTH'(1)) ? S_DONE : S_FETCH;
          end else begin
            state_d = S_CMP_MAX;
          end
        end
      end
      S_CMP_MAX: begin
        if (cmp_gt) begin
          max_d    = cur_q;
          maxidx_d = idx_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        // Strict compares only: ties keep the earlier index.
        if (cmp_lt) begin
          min_d    = cur_q;
          minidx_d = idx_q;
        end
        idx_d   = idx_q + CNTWIDTH'(1);
        rem_d   = rem_q - CNTWIDTH'(1);
        state_d = (rem_q == CNTWIDTH'(1)) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      cur_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      minidx_q <= '0;
      maxidx_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      min_q    <= min_d;
      max_q    <= max_d;
      minidx_q <= minidx_d;
      maxidx_q <= maxidx_d;
    end
  end

  assign InReady = (state_q == S_FETCH);
  assign Busy    = (state_q == S_FETCH) || (state_q == S_CMP_MAX) || (state_q == S_CMP_MIN);
  assign Done    = (state_q == S_DONE);
  assign Min     = min_q;
  assign Max     = max_q;
  assign MinIdx  = minidx_q;
  assign MaxIdx  = maxidx_q;

endmodule
